set_value_editor: RTL and testbench

- Edit engine for the user-settable hour:min and min:sec pairs. Turns the debounced up/down buttons into increments and decrements, with auto-repeat while a button is held.
- Steps only the field enabled by the main state machine's set_left/set_right.
- Loaded by the copy strobe with the current clock/alarm/timer value; its outputs feed the clock, alarm and timer register inputs.

---
 rtl/set_value_editor_if.sv | 28 ++
 rtl/set_value_editor.sv | 170 +++++++++++++++++
 tb/tb_set_value_editor.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/set_value_editor_if.sv
// Button, field-select and load/edit signals between the mode controller and
// the set-value editor.
interface set_value_editor_if;
    logic       up_input;
    logic       down_input;
    logic       set_left;
    logic       set_right;
    logic       timer_mode;
    logic       copy;
    logic [6:0] load_left;
    logic [5:0] load_right;
    logic [6:0] left_value;
    logic [5:0] right_value;
    logic       changed;
    logic       holding;

    modport master (
        output up_input, down_input, set_left, set_right, timer_mode,
               copy, load_left, load_right,
        input  left_value, right_value, changed, holding
    );

    modport slave (
        input  up_input, down_input, set_left, set_right, timer_mode,
               copy, load_left, load_right,
        output left_value, right_value, changed, holding
    );
endinterface

// File: rtl/set_value_editor.sv
// Up/down edit engine for the hour:min / min:sec pair, with press-and-hold
// auto-repeat on the field selected by set_left/set_right.
module set_value_editor #(
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic              clk,
    input  logic              rst,
    set_value_editor_if.slave bus
);
    localparam logic [CNT_W-1:0] LP_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] LP_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [6:0]       LP_HOUR_MAX = 7'd23;
    localparam logic [6:0]       LP_TMIN_MAX = 7'd99;
    localparam logic [5:0]       LP_SEC_MAX  = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_up_q;
    logic             r_dn_q;
    logic             r_armed;
    logic             r_field_left;
    logic             w_field_left_nxt;
    logic             r_dir_up;
    logic             w_dir_up_nxt;
    logic [6:0]       r_left;
    logic [6:0]       w_left_nxt;
    logic [5:0]       r_right;
    logic [5:0]       w_right_nxt;
    logic             r_changed;
    logic             r_holding;
    logic             w_step;

    logic       w_sel_ok;
    logic       w_dir_ok;
    logic       w_press;
    logic       w_abort;
    logic [6:0] w_left_max;
    logic [6:0] w_left_stepped;
    logic [5:0] w_right_stepped;

    assign w_sel_ok   = bus.set_left ^ bus.set_right;
    assign w_dir_ok   = bus.up_input ^ bus.down_input;
    assign w_left_max = bus.timer_mode ? LP_TMIN_MAX : LP_HOUR_MAX;

    // r_armed blocks a button still held through reset from looking like a press
    assign w_press = w_sel_ok & w_dir_ok & r_armed &
                     (bus.up_input ? ~r_up_q : ~r_dn_q);
    assign w_abort = ~w_sel_ok | ~w_dir_ok |
                     (bus.set_left != r_field_left) | (bus.up_input != r_dir_up);

    // Wrap-around step; out-of-range values snap to 0 (up) or max (down)
    always_comb begin
        w_left_stepped  = r_left;
        w_right_stepped = r_right;
        if (bus.up_input) begin
            w_left_stepped  = (r_left >= w_left_max) ? 7'd0 : r_left + 7'd1;
            w_right_stepped = (r_right >= LP_SEC_MAX) ? 6'd0 : r_right + 6'd1;
        end else begin
            w_left_stepped  = (r_left == 7'd0 || r_left > w_left_max)
                              ? w_left_max : r_left - 7'd1;
            w_right_stepped = (r_right == 6'd0 || r_right > LP_SEC_MAX)
                              ? LP_SEC_MAX : r_right - 6'd1;
        end
    end

    // Next-state, hold counter, step decision and field update
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_step           = 1'b0;
        w_field_left_nxt = r_field_left;
        w_dir_up_nxt     = r_dir_up;
        w_left_nxt       = r_left;
        w_right_nxt      = r_right;

        if (bus.copy) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_left_nxt  = bus.load_left;
            w_right_nxt = bus.load_right;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        w_step           = 1'b1;
                        w_state_nxt      = ST_DELAY;
                        w_cnt_nxt        = '0;
                        w_field_left_nxt = bus.set_left;
                        w_dir_up_nxt     = bus.up_input;
                    end
                end
                ST_DELAY: begin
                    if (w_abort) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == LP_DLY_LAST) begin
                        w_step      = 1'b1;
                        w_state_nxt = ST_REPEAT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (w_abort) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == LP_PER_LAST) begin
                        w_step    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase

            if (w_step) begin
                if (bus.set_left) w_left_nxt  = w_left_stepped;
                else              w_right_nxt = w_right_stepped;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_up_q       <= 1'b0;
            r_dn_q       <= 1'b0;
            r_armed      <= 1'b0;
            r_field_left <= 1'b0;
            r_dir_up     <= 1'b0;
            r_left       <= '0;
            r_right      <= '0;
            r_changed    <= 1'b0;
            r_holding    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_up_q       <= bus.up_input;
            r_dn_q       <= bus.down_input;
            r_armed      <= r_armed | (~bus.up_input & ~bus.down_input);
            r_field_left <= w_field_left_nxt;
            r_dir_up     <= w_dir_up_nxt;
            r_left       <= w_left_nxt;
            r_right      <= w_right_nxt;
            r_changed    <= w_step;
            r_holding    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.left_value  = r_left;
    assign bus.right_value = r_right;
    assign bus.changed     = r_changed;
    assign bus.holding     = r_holding;
endmodule

// File: tb/tb_set_value_editor.sv
// Randomized and directed bench for set_value_editor against a hold-age model.
module tb_set_value_editor;
    localparam int unsigned DLY = 4;
    localparam int unsigned PER = 2;

    logic clk;
    logic rst;
    set_value_editor_if u_if ();

    set_value_editor #(
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER),
        .CNT_W        (8)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    // Model: press age counted from the press step; no state encoding reused
    bit m_active, m_field_left, m_dir_up, m_prev_up, m_prev_dn, m_armed, m_changed;
    int m_age, m_left, m_right;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_val(input int v, input int mx, input bit up);
        if (up) return (v >= mx) ? 0 : v + 1;
        return (v == 0 || v > mx) ? mx : v - 1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_age = 0; m_field_left = 0; m_dir_up = 0;
        m_prev_up = 0; m_prev_dn = 0; m_armed = 0; m_changed = 0;
        m_left = 0; m_right = 0;
    endtask

    task automatic model_edge();
        bit up, dn, sel_ok, dir_ok, do_step, press;
        up = u_if.up_input; dn = u_if.down_input;
        sel_ok = u_if.set_left ^ u_if.set_right;
        dir_ok = up ^ dn;
        do_step = 0;
        if (u_if.copy) begin
            m_left = int'(u_if.load_left); m_right = int'(u_if.load_right);
            m_active = 0;
        end else if (m_active) begin
            if (!sel_ok || !dir_ok || (u_if.set_left != m_field_left) || (up != m_dir_up)) begin
                m_active = 0;
            end else begin
                m_age++;
                do_step = (m_age == DLY) ||
                          (m_age > DLY && ((m_age - DLY) % PER) == 0);
            end
        end else begin
            press = sel_ok && dir_ok && m_armed && (up ? !m_prev_up : !m_prev_dn);
            if (press) begin
                m_active = 1; m_age = 0; do_step = 1;
                m_field_left = u_if.set_left; m_dir_up = up;
            end
        end
        if (do_step) begin
            if (u_if.set_left) m_left  = step_val(m_left, u_if.timer_mode ? 99 : 23, up);
            else               m_right = step_val(m_right, 59, up);
        end
        m_changed = do_step;
        m_prev_up = up; m_prev_dn = dn;
        m_armed   = m_armed | (!up && !dn);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_val("left_value",  int'(u_if.left_value),  m_left);
        check_val("right_value", int'(u_if.right_value), m_right);
        check_val("changed",     int'(u_if.changed),     int'(m_changed));
        check_val("holding",     int'(u_if.holding),     int'(m_active));
        if (u_if.changed) n_pulses++;
    endtask

    task automatic set_in(input bit up, input bit dn, input bit sl, input bit sr);
        u_if.up_input = up; u_if.down_input = dn;
        u_if.set_left = sl; u_if.set_right = sr;
    endtask

    task automatic load(input int l, input int r);
        u_if.copy = 1'b1; u_if.load_left = 7'(l); u_if.load_right = 6'(r);
        tick();
        u_if.copy = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        u_if.timer_mode = 1'b0; u_if.copy = 1'b0;
        u_if.load_left = '0; u_if.load_right = '0;
        model_reset();
        #12;
        check_val("rst_left",    int'(u_if.left_value),  0);
        check_val("rst_right",   int'(u_if.right_value), 0);
        check_val("rst_changed", int'(u_if.changed),     0);
        check_val("rst_holding", int'(u_if.holding),     0);
        @(negedge clk); rst = 1'b0;
        tick();

        // Hours wrap up: one pulse over a 3-cycle press
        load(23, 17);
        n_pulses = 0;
        set_in(1, 0, 1, 0);
        repeat (3) tick();
        set_in(0, 0, 1, 0); tick();
        check_val("hour_wrap", int'(u_if.left_value), 0);
        check_val("hour_wrap_right", int'(u_if.right_value), 17);
        check_val("hour_wrap_pulses", n_pulses, 1);

        // Minutes wrap down
        load(5, 0);
        set_in(0, 1, 0, 1); tick();
        set_in(0, 0, 0, 1); tick();
        check_val("min_wrap", int'(u_if.right_value), 59);

        // Timer left wraps at 99
        u_if.timer_mode = 1'b1;
        load(99, 3);
        set_in(1, 0, 1, 0); tick();
        set_in(0, 0, 1, 0); tick();
        check_val("timer_wrap", int'(u_if.left_value), 0);
        u_if.timer_mode = 1'b0;

        // Auto-repeat: steps at edges 0,4,6,8
        load(1, 10);
        n_pulses = 0;
        set_in(1, 0, 0, 1);
        tick();
        check_val("hold_edge0", int'(u_if.holding), 1);
        repeat (9) tick();
        check_val("repeat_right", int'(u_if.right_value), 14);
        check_val("repeat_pulses", n_pulses, 4);
        set_in(0, 0, 0, 1); tick();

        // Conflicts: both buttons, both selects, copy with press edge
        set_in(1, 1, 0, 1); repeat (3) tick();
        set_in(0, 0, 0, 1); tick();
        set_in(1, 0, 1, 1); repeat (3) tick();
        set_in(0, 0, 0, 1); tick();
        check_val("conflict_right", int'(u_if.right_value), 14);
        set_in(1, 0, 0, 1);
        load(7, 33);
        check_val("copy_press_changed", int'(u_if.changed), 0);
        check_val("copy_press_right", int'(u_if.right_value), 33);
        tick();
        set_in(0, 0, 0, 1); tick();

        // Abort mid-DELAY by switching field
        set_in(1, 0, 0, 1); repeat (2) tick();
        set_in(1, 0, 1, 0); repeat (6) tick();
        check_val("abort_left", int'(u_if.left_value), 7);
        check_val("abort_right", int'(u_if.right_value), 34);
        set_in(0, 0, 1, 0); tick();

        // Async reset mid-REPEAT with button still held
        set_in(1, 0, 0, 1); repeat (8) tick();
        @(negedge clk); rst = 1'b1; #1;
        check_val("async_left",    int'(u_if.left_value),  0);
        check_val("async_right",   int'(u_if.right_value), 0);
        check_val("async_changed", int'(u_if.changed),     0);
        check_val("async_holding", int'(u_if.holding),     0);
        model_reset();
        #2 rst = 1'b0;
        repeat (4) tick();
        check_val("held_after_rst", int'(u_if.right_value), 0);
        set_in(0, 0, 0, 1); tick();
        set_in(1, 0, 0, 1); tick();
        check_val("repress_after_rst", int'(u_if.right_value), 1);

        // Randomized traffic with run-length-biased buttons
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)  u_if.up_input   = 1'($urandom_range(1));
            if ($urandom_range(7) == 0)  u_if.down_input = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) begin
                u_if.set_left  = 1'($urandom_range(1));
                u_if.set_right = 1'($urandom_range(1));
            end
            if ($urandom_range(63) == 0) u_if.timer_mode = ~u_if.timer_mode;
            u_if.copy       = ($urandom_range(31) == 0);
            u_if.load_left  = 7'($urandom_range(127));
            u_if.load_right = 6'($urandom_range(63));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
